cmd_frame_tx: RTL and testbench

Serialises the pulse-generator configuration into the 9-byte UART command frame and hands it to `uart_tx` one byte at a time. It is the transmit end of the frame protocol that the receive-side parser decodes: header, channel-1 enable, channel-2 enable, width1, width2 and gap. It sits between the configuration registers and `uart_tx` in `top_functionGenerate`. It drives `uart_tx`'s `pi_data`/`pi_flag` directly. `uart_tx` has no ready signal, so this block paces the bytes itself.

---
 rtl/cmd_frame_pkg.sv | 39 +++
 rtl/cmd_frame_tx_pacer.sv | 37 +++
 rtl/cmd_frame_tx.sv | 165 ++++++++++++++++
 tb/tb_cmd_frame_tx.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/cmd_frame_pkg.sv
// Shared definitions for the UART command frame (transmit serialiser and receive parser).
// Optional CMD_FRAME_CKSUM_EN appends a mod-256 checksum byte after the gap field.
package cmd_frame_pkg;

    localparam logic [7:0] FRAME_HDR_DEFAULT = 8'h07;
    localparam int         FRAME_LEN         = 9;

    localparam logic [3:0] IDX_HDR    = 4'd0;
    localparam logic [3:0] IDX_SEL1   = 4'd1;
    localparam logic [3:0] IDX_SEL2   = 4'd2;
    localparam logic [3:0] IDX_W1_HI  = 4'd3;
    localparam logic [3:0] IDX_W1_LO  = 4'd4;
    localparam logic [3:0] IDX_W2_HI  = 4'd5;
    localparam logic [3:0] IDX_W2_LO  = 4'd6;
    localparam logic [3:0] IDX_GAP_HI = 4'd7;
    localparam logic [3:0] IDX_GAP_LO = 4'd8;
    localparam logic [3:0] IDX_CKSUM  = 4'd9;

`ifdef CMD_FRAME_CKSUM_EN
    localparam logic [3:0] IDX_LAST = IDX_CKSUM;
`else
    localparam logic [3:0] IDX_LAST = IDX_GAP_LO;
`endif

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } tx_state_e;

    typedef struct packed {
        logic [1:0]  sel;
        logic [15:0] width1;
        logic [15:0] width2;
        logic [15:0] gap;
    } frame_cfg_t;

endpackage

// File: rtl/cmd_frame_tx_pacer.sv
// Byte pacing down-counter: load arms it, expire is high once BYTE_CYCLES-1 cycles have elapsed.
// Latency: expire rises on the (BYTE_CYCLES-1)th cycle after load; no backpressure (free-running).
module tx_pacer #(
    parameter int BYTE_CYCLES = 110
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic load,
    output logic expire
);

    localparam int CW = $clog2(BYTE_CYCLES);
    // The load cycle itself is the first of the byte period, hence -2 for a terminal count at zero.
    localparam logic [CW-1:0] LOAD_VAL = CW'(BYTE_CYCLES - 2);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = LOAD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/cmd_frame_tx.sv
// Serialises the pulse configuration into the UART command frame, one pi_flag strobe per byte.
// Latency: header strobe 1 cycle after accepted send_req, then one byte every BYTE_CYCLES; done after the last.
// Backpressure: none from uart_tx; bytes are self-paced and send_req while busy is dropped. Option: CMD_FRAME_CKSUM_EN.
module cmd_frame_tx
    import cmd_frame_pkg::*;
#(
    parameter int         UART_BPS  = 9600,
    parameter int         CLK_FREQ  = 50_000_000,
    parameter logic [7:0] FRAME_HDR = FRAME_HDR_DEFAULT,
    parameter int         GAP_BITS  = 11
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        send_req,
    input  logic [1:0]  pulse_select,
    input  logic [15:0] pulse_width1,
    input  logic [15:0] pulse_width2,
    input  logic [15:0] pulse_gap,
    output logic [7:0]  pi_data,
    output logic        pi_flag,
    output logic        busy,
    output logic        done
);

    localparam int BIT_CYCLES  = CLK_FREQ / UART_BPS;
    localparam int BYTE_CYCLES = BIT_CYCLES * GAP_BITS;

    tx_state_e  state_q, state_d;
    logic [3:0] idx_q, idx_d;
    frame_cfg_t cfg_q, cfg_d, cfg_in;
    logic [7:0] pi_data_q, pi_data_d;
    logic       pi_flag_q, pi_flag_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic [7:0] cur_byte;
    logic       pacer_load;
    logic       pacer_expire;
`ifdef CMD_FRAME_CKSUM_EN
    logic [7:0] sum_q, sum_d;
`endif

    assign cfg_in = '{sel: pulse_select, width1: pulse_width1, width2: pulse_width2, gap: pulse_gap};

    tx_pacer #(
        .BYTE_CYCLES (BYTE_CYCLES)
    ) u_pacer (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .load      (pacer_load),
        .expire    (pacer_expire)
    );

    always_comb begin
        cur_byte = 8'h00;
        case (idx_q)
            IDX_HDR:    cur_byte = FRAME_HDR;
            IDX_SEL1:   cur_byte = {7'b0, cfg_q.sel[0]};
            IDX_SEL2:   cur_byte = {7'b0, cfg_q.sel[1]};
            IDX_W1_HI:  cur_byte = cfg_q.width1[15:8];
            IDX_W1_LO:  cur_byte = cfg_q.width1[7:0];
            IDX_W2_HI:  cur_byte = cfg_q.width2[15:8];
            IDX_W2_LO:  cur_byte = cfg_q.width2[7:0];
            IDX_GAP_HI: cur_byte = cfg_q.gap[15:8];
            IDX_GAP_LO: cur_byte = cfg_q.gap[7:0];
`ifdef CMD_FRAME_CKSUM_EN
            IDX_CKSUM:  cur_byte = sum_q;
`endif
            default:    cur_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cfg_d      = cfg_q;
        pi_data_d  = pi_data_q;
        pi_flag_d  = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        pacer_load = 1'b0;
`ifdef CMD_FRAME_CKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (send_req && !busy_q) begin
                    cfg_d   = cfg_in;
                    idx_d   = IDX_HDR;
                    busy_d  = 1'b1;
                    state_d = ST_SEND;
`ifdef CMD_FRAME_CKSUM_EN
                    sum_d   = 8'h00;
`endif
                end
            end
            ST_SEND: begin
                pi_flag_d  = 1'b1;
                pi_data_d  = cur_byte;
                busy_d     = 1'b1;
                pacer_load = 1'b1;
                state_d    = ST_WAIT;
`ifdef CMD_FRAME_CKSUM_EN
                sum_d      = sum_q + cur_byte;
`endif
            end
            ST_WAIT: begin
                if (pacer_expire) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        state_d = ST_SEND;
                    end
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                // Accepting here lets the next header follow done with no idle gap.
                if (send_req) begin
                    cfg_d   = cfg_in;
                    idx_d   = IDX_HDR;
                    state_d = ST_SEND;
`ifdef CMD_FRAME_CKSUM_EN
                    sum_d   = 8'h00;
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= 4'd0;
            cfg_q     <= '0;
            pi_data_q <= 8'h00;
            pi_flag_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef CMD_FRAME_CKSUM_EN
            sum_q     <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cfg_q     <= cfg_d;
            pi_data_q <= pi_data_d;
            pi_flag_q <= pi_flag_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
`ifdef CMD_FRAME_CKSUM_EN
            sum_q     <= sum_d;
`endif
        end
    end

    assign pi_data = pi_data_q;
    assign pi_flag = pi_flag_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_cmd_frame_tx.sv
// Directed bench for cmd_frame_tx with CLK_FREQ=1000, UART_BPS=100 (110-cycle byte period).
// Offsets are counted in clock edges after the edge that samples send_req.
module tb_cmd_frame_tx;

    localparam int BC = 110;
`ifdef CMD_FRAME_CKSUM_EN
    localparam int NB = 10;
`else
    localparam int NB = 9;
`endif
    localparam int DONE_OFF = 1 + NB * BC;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        send_req = 1'b0;
    logic [1:0]  pulse_select = 2'b00;
    logic [15:0] pulse_width1 = 16'h0;
    logic [15:0] pulse_width2 = 16'h0;
    logic [15:0] pulse_gap = 16'h0;
    logic [7:0]  pi_data;
    logic        pi_flag;
    logic        busy;
    logic        done;

    cmd_frame_tx #(
        .UART_BPS  (100),
        .CLK_FREQ  (1000),
        .FRAME_HDR (8'h07),
        .GAP_BITS  (11)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .send_req     (send_req),
        .pulse_select (pulse_select),
        .pulse_width1 (pulse_width1),
        .pulse_width2 (pulse_width2),
        .pulse_gap    (pulse_gap),
        .pi_data      (pi_data),
        .pi_flag      (pi_flag),
        .busy         (busy),
        .done         (done)
    );

    always #5 sys_clk = ~sys_clk;

    int         nvec = 0;
    int         nerr = 0;
    int         flag_off [16];
    logic [7:0] flag_dat [16];
    int         nflags, done_off, ndone, busy_lo_off, holdviol;
    logic       busy_tr [0:2047];
    logic [7:0] exp_b [10];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_inputs(input logic [1:0] sel, input logic [15:0] w1,
                              input logic [15:0] w2, input logic [15:0] gap);
        pulse_select = sel;
        pulse_width1 = w1;
        pulse_width2 = w2;
        pulse_gap    = gap;
    endtask

    // Bytes 0..8 hand-written, MSB-first; slot 9 is their mod-256 sum.
    task automatic load_exp(input logic [71:0] v);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < 9; i++) begin
            exp_b[i] = v[71 - 8*i -: 8];
            s = s + exp_b[i];
        end
        exp_b[9] = s;
    endtask

    task automatic request();
        send_req = 1'b1;
        @(posedge sys_clk);
        #1;
        send_req = 1'b0;
    endtask

    task automatic watch(input int ncyc, input int chg_at, input int req_at);
        nflags = 0; done_off = -1; ndone = 0; busy_lo_off = -1; holdviol = 0;
        for (int i = 0; i < 16; i++) begin
            flag_off[i] = -1;
            flag_dat[i] = 8'hxx;
        end
        for (int t = 1; t <= ncyc; t++) begin
            @(posedge sys_clk);
            #1;
            busy_tr[t] = busy;
            if (pi_flag) begin
                if (nflags < 16) begin
                    flag_off[nflags] = t;
                    flag_dat[nflags] = pi_data;
                end
                nflags++;
            end else if (nflags > 0 && nflags <= 16 && pi_data !== flag_dat[nflags-1]) begin
                holdviol++;
            end
            if (done) begin
                ndone++;
                if (done_off < 0) done_off = t;
            end
            if (!busy && busy_lo_off < 0) busy_lo_off = t;
            if (t == chg_at) set_inputs(2'b11, 16'hFFFF, 16'hFFFF, 16'hFFFF);
            if (t == req_at - 1) send_req = 1'b1;
            if (t == req_at) send_req = 1'b0;
        end
    endtask

    task automatic check_frame(input string nm, input int nexp);
        chk({nm, "_nflags"}, nflags, nexp);
        for (int i = 0; i < NB; i++) begin
            chk($sformatf("%s_off%0d", nm, i), flag_off[i], 1 + i * BC);
            chk($sformatf("%s_byte%0d", nm, i), {24'h0, flag_dat[i]}, {24'h0, exp_b[i]});
        end
        chk({nm, "_done_off"}, done_off, DONE_OFF);
        chk({nm, "_busy_low"}, busy_lo_off, DONE_OFF);
        chk({nm, "_hold"}, holdviol, 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_pi_data", pi_data, 8'h00);
        chk("rst_pi_flag", pi_flag, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        sys_rst_n = 1'b1;
        @(posedge sys_clk);
        #1;
        chk("post_rst_busy", busy, 1'b0);

        // Scenario 1: select=01, w1=1500, w2=500, gap=500
        set_inputs(2'b01, 16'd1500, 16'd500, 16'd500);
        load_exp(72'h07_01_00_05DC_01F4_01F4);
`ifdef CMD_FRAME_CKSUM_EN
        chk("s1_cksum_table", {24'h0, exp_b[9]}, 32'hD3);
`endif
        request();
        chk("s1_busy_at_k", busy, 1'b1);
        chk("s1_flag_at_k", pi_flag, 1'b0);
        watch(DONE_OFF + 5, -1, -1);
        check_frame("s1", NB);
        chk("s1_ndone", ndone, 1);

        // Scenario 2: extreme field values
        set_inputs(2'b11, 16'h0000, 16'hFFFF, 16'h0004);
        load_exp(72'h07_01_01_0000_FFFF_0004);
        request();
        watch(DONE_OFF + 5, -1, -1);
        check_frame("s2", NB);

        // Scenario 3: inputs change mid-frame, request while busy is dropped
        set_inputs(2'b10, 16'h1234, 16'h5678, 16'h9ABC);
        load_exp(72'h07_00_01_1234_5678_9ABC);
        request();
        watch(DONE_OFF + 20, 50, 300);
        check_frame("s3", NB);
        chk("s3_ndone", ndone, 1);

        // Scenario 4: request in the DONE cycle gives a back-to-back frame
        set_inputs(2'b01, 16'd1500, 16'd500, 16'd500);
        load_exp(72'h07_01_00_05DC_01F4_01F4);
        request();
        watch(DONE_OFF + 3, -1, DONE_OFF);
        check_frame("s4", NB + 1);
        chk("s4_next_hdr_off", flag_off[NB], DONE_OFF + 1);
        chk("s4_next_hdr_byte", {24'h0, flag_dat[NB]}, 32'h07);
        chk("s4_busy_before_done", busy_tr[DONE_OFF - 1], 1'b1);
        chk("s4_busy_after_done", busy_tr[DONE_OFF + 1], 1'b1);
        sys_rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;

        // Scenario 5: reset after the byte-3 strobe abandons the frame
        request();
        watch(3 * BC + 2, -1, -1);
        chk("s5_flags_before_rst", nflags, 4);
        chk("s5_byte3", {24'h0, flag_dat[3]}, 32'h05);
        sys_rst_n = 1'b0;
        #1;
        chk("s5_rst_pi_data", pi_data, 8'h00);
        chk("s5_rst_pi_flag", pi_flag, 1'b0);
        chk("s5_rst_busy", busy, 1'b0);
        chk("s5_rst_done", done, 1'b0);
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        watch(400, -1, -1);
        chk("s5_no_flags", nflags, 0);
        chk("s5_no_done", ndone, 0);
        chk("s5_busy_stays_low", busy_lo_off, 1);
        request();
        chk("s5_restart_busy", busy, 1'b1);
        watch(3, -1, -1);
        chk("s5_restart_nflags", nflags, 1);
        chk("s5_restart_off", flag_off[0], 1);
        chk("s5_restart_hdr", {24'h0, flag_dat[0]}, 32'h07);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
